// File: rtl/stream_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : stream_packetizer
// Description : Cuts an AXI-Stream input into packets of 'count' beats and
//               tags the final beat of each packet with tlast. A start pulse
//               arms one packet, or a back-to-back series in continuous mode,
//               which ends after the packet in flight when stop is pulsed.
//               Beats pass through a 2-entry skid buffer. The output
//               register is the first entry and the skid register is the
//               second.
//
// Ports       : clk, resetn          clock, async active-low reset
//               start, stop          arm request / end-of-continuous request
//               continuous, count    mode and beats per packet (CNT_W)
//               busy                 high while RUN or FLUSH
//               s_axis_*             slave stream (tdata/tvalid/tready)
//               m_axis_*             master stream (tdata/tvalid/tlast/tready)
//               pkt_done_cnt         completed-packet counter (optional)
//
// Options     : define STREAM_PACKETIZER_PKT_CNT_EN to add pkt_done_cnt[31:0].
//               It counts tlast handshakes on m_axis and wraps to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module stream_packetizer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 25
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
`ifdef STREAM_PACKETIZER_PKT_CNT_EN
  ,
  output logic [31:0]       pkt_done_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              cont_q, cont_d;
  logic              stop_pend_q, stop_pend_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic              skid_last_q, skid_last_d;

  logic w_start_ok;
  logic w_accept;
  logic w_tag_last;
  logic w_pop;
  logic w_stop_now;
  logic w_wrap;
  logic w_buf_empty;

  assign w_start_ok  = start && (count != '0);
  assign w_accept    = s_axis_tvalid && ready_q && (state_q == S_RUN);
  assign w_tag_last  = (beat_q == (count_q - CNT_W'(1)));
  assign w_pop       = out_valid_q && m_axis_tready;
  // A stop that coincides with the tlast acceptance still ends the series.
  assign w_stop_now  = stop_pend_q || stop;
  // A resampled count of zero cannot form a packet, so it ends the series too.
  assign w_wrap      = w_accept && w_tag_last && cont_q && !w_stop_now && (count != '0);
  assign w_buf_empty = !out_valid_q && !skid_valid_q;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_start_ok) state_d = S_RUN;
      S_RUN:   if (w_accept && w_tag_last && !w_wrap) state_d = S_FLUSH;
      S_FLUSH: if (w_buf_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_FLUSH);
  end

  // --------------------------------------------------------------------------
  // Packet control: beat counter, latched count/mode, pending stop
  // --------------------------------------------------------------------------
  always_comb begin
    count_d     = count_q;
    cont_d      = cont_q;
    beat_d      = beat_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE: begin
        if (w_start_ok) begin
          count_d     = count;
          cont_d      = continuous;
          beat_d      = '0;
          stop_pend_d = stop;
        end
      end
      S_RUN: begin
        if (stop) stop_pend_d = 1'b1;
        if (w_accept) begin
          if (w_tag_last) begin
            if (w_wrap) begin
              beat_d  = '0;
              count_d = count;
            end
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
    if ((state_d == S_IDLE) && (state_q != S_IDLE)) stop_pend_d = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Skid buffer. The output register is refilled from the skid entry first
  // so that beat order is preserved. The skid entry fills only while the
  // output register is stalled.
  // --------------------------------------------------------------------------
  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;
    if (!out_valid_q || w_pop) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_valid_d  = 1'b1;
        skid_valid_d = w_accept;
        if (w_accept) begin
          skid_data_d = s_axis_tdata;
          skid_last_d = w_tag_last;
        end
      end else if (w_accept) begin
        out_data_d  = s_axis_tdata;
        out_last_d  = w_tag_last;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_data_d  = s_axis_tdata;
      skid_last_d  = w_tag_last;
      skid_valid_d = 1'b1;
    end
  end

  // The ready flag is registered. It therefore looks at the buffer and state
  // as they will be next cycle.
  always_comb begin
    case (state_d)
      S_IDLE:  ready_d = 1'b1;
      S_RUN:   ready_d = !(out_valid_d && skid_valid_d);
      default: ready_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q      <= '0;
      cont_q       <= 1'b0;
      beat_q       <= '0;
      stop_pend_q  <= 1'b0;
      ready_q      <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      cont_q       <= cont_d;
      beat_q       <= beat_d;
      stop_pend_q  <= stop_pend_d;
      ready_q      <= ready_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;

`ifdef STREAM_PACKETIZER_PKT_CNT_EN
  logic [31:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt_q <= '0;
    end else if (out_valid_q && m_axis_tready && out_last_q) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign pkt_done_cnt = pkt_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_packetizer
// Description : Self-checking bench for stream_packetizer. Random source and
//               sink traffic is scored against a packet model. In that model
//               the n-th beat accepted after start carries tlast exactly
//               when n mod count == count-1. The output must replay the
//               accepted beats in order. In continuous mode the number of
//               packets is fixed by when stop is pulsed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_packetizer;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 25;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic              stop;
  logic              continuous;
  logic [CNT_W-1:0]  count;
  logic              busy;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
`ifdef STREAM_PACKETIZER_PKT_CNT_EN
  logic [31:0]       pkt_done_cnt;
`endif

  int checks = 0;
  int errors = 0;

  stream_packetizer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .stop          (stop),
    .continuous    (continuous),
    .count         (count),
    .busy          (busy),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
`ifdef STREAM_PACKETIZER_PKT_CNT_EN
    ,
    .pkt_done_cnt  (pkt_done_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One start and the whole resulting transfer.
  // stop_at < 0 : no stop pulse
  // stop_at = 0 : stop is pulsed together with start
  // stop_at > 0 : stop is pulsed when that many beats have been accepted
  // rmode       : sink ready pattern (0 always, 1 one cycle in three, 2 random)
  task automatic run_test(input int cnt, input bit cont, input int stop_at,
                          input int vpct, input int rmode);
    logic [DATA_W:0]   q[$];
    logic [DATA_W:0]   exp_beat;
    logic [DATA_W-1:0] prev_data;
    logic              prev_last;
    bit                prev_stall;
    bit                stop_sent;
    bit                seen_valid;
    int                acc, outc, total, after, cyc, first_acc;
    acc = 0; outc = 0; after = -1; cyc = 0; first_acc = -1;
    prev_stall = 0; stop_sent = 0; seen_valid = 0;
    prev_data = '0; prev_last = 1'b0;
    total = cont ? -1 : cnt;

    @(negedge clk);
    start = 1'b1; count = CNT_W'(cnt); continuous = cont; s_axis_tvalid = 1'b0;
    stop = (stop_at == 0);
    if (stop_at == 0) begin
      stop_sent = 1;
      total = cnt;
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("busy_after_start", busy, 1);

    forever begin
      if (prev_stall) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_tdata", m_axis_tdata, prev_data);
        check("stall_tlast", m_axis_tlast, prev_last);
      end
      if (!seen_valid && m_axis_tvalid) begin
        seen_valid = 1;
        if (vpct == 100 && rmode == 0) check("first_beat_latency", cyc - first_acc, 1);
      end
      if (after == 1) check("busy_while_flush", busy, 1);
      if (after == 2) begin
        check("busy_idle", busy, 0);
        check("tvalid_idle", m_axis_tvalid, 0);
        break;
      end
      if (cyc > 3000) begin
        check("timeout_beats_out", outc, total);
        break;
      end

      s_axis_tvalid = ($urandom_range(99) < vpct);
      s_axis_tdata  = DATA_W'($urandom);
      case (rmode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (cyc % 3 == 0);
        default: m_axis_tready = 1'($urandom_range(1));
      endcase
      start = ($urandom_range(9) == 0);   // must be ignored while busy
      if (!cont) count = CNT_W'($urandom); // mid-packet change must be ignored
      if (cont && !stop_sent && acc == stop_at) begin
        stop = 1'b1;
        stop_sent = 1;
        total = (acc / cnt + 1) * cnt;
      end else begin
        stop = 1'b0;
      end

      if (s_axis_tvalid && s_axis_tready) begin
        q.push_back({(acc % cnt) == cnt - 1, s_axis_tdata});
        if (first_acc < 0) first_acc = cyc;
        acc++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          check("extra_out_beat", q.size(), 1);
        end else begin
          exp_beat = q.pop_front();
          check("out_tdata", m_axis_tdata, exp_beat[DATA_W-1:0]);
          check("out_tlast", m_axis_tlast, exp_beat[DATA_W]);
        end
        outc++;
        if (outc == total) after = 0;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (after >= 0) after++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0; s_axis_tvalid = 1'b0;
    check("accepted_total", acc, total);
    check("model_queue_empty", q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tready"}, s_axis_tready, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int acc;
    int cyc;
    int cnt;
    bit cont;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; count = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1 check("tready_before_edge", s_axis_tready, 0);
    @(posedge clk); #1;
    check("tready_after_release", s_axis_tready, 1);

    // Basic single packet, free-flowing source and sink.
    run_test(4, 1'b0, -1, 100, 0);
    // Sink stalls two cycles in three.
    run_test(8, 1'b0, -1, 100, 1);
    // Continuous, stop during the second packet: 6 beats.
    run_test(3, 1'b1, 4, 100, 0);

    // A start with count 0 is ignored.
    @(negedge clk);
    start = 1'b1; count = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      s_axis_tvalid = 1'($urandom_range(1));
      m_axis_tready = 1'b1;
      check("cnt0_busy", busy, 0);
      check("cnt0_tvalid", m_axis_tvalid, 0);
    end
    s_axis_tvalid = 1'b0;

    // Single-beat packets.
    run_test(1, 1'b0, -1, 70, 2);
    run_test(1, 1'b1, 3, 80, 2);
    // Start and stop together: exactly one packet.
    run_test(3, 1'b1, 0, 80, 2);

    for (int t = 0; t < 6; t++) begin
      cnt  = $urandom_range(1, 6);
      cont = 1'($urandom_range(1));
      run_test(cnt, cont, $urandom_range(0, 2 * cnt), $urandom_range(30, 100), 2);
    end

    // Reset after two of five beats are accepted.
    @(negedge clk);
    start = 1'b1; count = CNT_W'(5); continuous = 1'b0;
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    acc = 0; cyc = 0;
    @(negedge clk);
    start = 1'b0;
    while (acc < 2 && cyc < 20) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DATA_W'($urandom);
      if (s_axis_tready) acc++;
      cyc++;
      @(negedge clk);
    end
    check("pre_reset_accepted", acc, 2);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_tvalid", m_axis_tvalid, 1);
    check("pre_reset_no_tlast", m_axis_tlast, 0);
    s_axis_tvalid = 1'b0;
    resetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    m_axis_tready = 1'b1;
    resetn = 1'b1;
    @(posedge clk); #1;
    check("tready_after_rst", s_axis_tready, 1);
    check("no_tvalid_after_rst", m_axis_tvalid, 0);

    // Three single-mode packets after reset, the first a full 5-beat packet.
    run_test(5, 1'b0, -1, 90, 2);
    run_test(1, 1'b0, -1, 90, 2);
    run_test(2, 1'b0, -1, 90, 2);
`ifdef STREAM_PACKETIZER_PKT_CNT_EN
    check("pkt_done_cnt", pkt_done_cnt, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_packetizer.md
STREAM_PACKETIZER -- requirements
Module: stream_packetizer

Interface
REQ-001 Parameter DATA_W, default 16: tdata width in bits.
REQ-002 Parameter CNT_W, default 25: width of count and internal beat counter.
REQ-003 clk  input  1  AXI-Stream clock; all logic on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle arm request; sampled only in IDLE.
REQ-006 stop  input  1  one-cycle request to end continuous mode after the current packet.
REQ-007 continuous  input  1  0 = single packet per start; 1 = back-to-back packets until stop; sampled with start.
REQ-008 count  input  CNT_W  beats per packet; sampled at start and at each packet boundary.
REQ-009 busy  output  1  high in RUN and FLUSH.
REQ-010 s_axis_tdata/s_axis_tvalid/s_axis_tready  input/input/output  DATA_W/1/1  slave stream.
REQ-011 m_axis_tdata/m_axis_tvalid/m_axis_tlast/m_axis_tready  output/output/output/input  DATA_W/1/1/1  master stream.

Function
REQ-012 States IDLE, RUN and FLUSH, encoded in 2 bits.
REQ-013 A beat SHALL be counted only on a handshake (s_axis_tvalid & s_axis_tready), never on tvalid edges.
REQ-014 IDLE: s_axis_tready=1, accepted beats discarded, m_axis_tvalid=0; start with count!=0 latches count and continuous, clears the beat counter and enters RUN next cycle.
REQ-015 start with count==0 SHALL be ignored; state remains IDLE.
REQ-016 RUN: accepted beats enter a 2-entry skid buffer; s_axis_tready is registered and low only while the buffer holds 2 entries.
REQ-017 Latency: an accepted beat SHALL appear on m_axis, with registered outputs, on the cycle after acceptance when the buffer is empty.
REQ-018 The beat accepted at beat counter value count_q-1 SHALL be tagged tlast; tlast travels with its data through the buffer.
REQ-019 On a tlast-tagged acceptance with continuous_q=1 and no stop pending: beat counter resets to 0, count is resampled, state stays RUN, and no beat is lost or duplicated.
REQ-020 On a tlast-tagged acceptance otherwise: enter FLUSH, s_axis_tready=0.
REQ-021 FLUSH: hold s_axis_tready=0; return to IDLE on the cycle after the buffer becomes empty.
REQ-022 m_axis_tdata, m_axis_tvalid and m_axis_tlast SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 stop in RUN sets stop_pending; the current packet completes at full length; stop_pending clears on entry to IDLE; stop in IDLE or FLUSH is ignored.
REQ-024 Simultaneous start and stop in IDLE: start is honoured, stop_pending is set, and exactly one packet is sent.
REQ-025 Simultaneous stop and tlast-tagged acceptance: that packet is the last one.
REQ-026 start in RUN or FLUSH is ignored; count changes mid-packet have no effect.
REQ-027 count==1 SHALL produce single-beat packets, each with tlast=1.
REQ-028 The beat counter SHALL never wrap; the maximum count is 2^CNT_W-1 beats.

Reset
REQ-029 On resetn=0, immediately: state=IDLE, buffer empty, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, busy=0, stop_pending=0, counter=0.
REQ-030 s_axis_tready SHALL rise on the first clk edge after resetn deasserts.
REQ-031 Reset mid-packet SHALL drop buffered beats without emitting tlast.

Configuration
REQ-032 Macro STREAM_PACKETIZER_PKT_CNT_EN: when defined, adds output pkt_done_cnt [31:0], reset to 0, incremented when a tlast beat handshakes on m_axis, wrapping at 2^32-1 to 0.
REQ-033 Without the macro, the port and the counter SHALL be absent and behaviour is otherwise identical.

Verification
REQ-034 count=4, continuous=0, source always valid, sink always ready -> 4 m_axis beats, tlast on the 4th only, busy low 1 cycle after the buffer empties.
REQ-035 count=8, sink ready toggling 1-of-3 cycles -> output data order equals input order, tdata/tlast stable under stall, no beat lost.
REQ-036 continuous=1, count=3, stop pulsed during the 2nd packet -> exactly 6 beats, tlast on beats 3 and 6, then IDLE.
REQ-037 start with count=0 -> busy stays 0 and m_axis_tvalid stays 0; count=1 -> one beat with tlast=1.
REQ-038 resetn pulsed low after 2 of 5 beats -> outputs zero immediately, no tlast emitted; restart with count=5 -> a full 5-beat packet.
REQ-039 With the macro defined, 3 single-mode packets sent -> pkt_done_cnt=3.
